// File: rtl/fractal_iter_pkg.sv
// -----------------------------------------------------------------------------
// fractal_pkg
// Shared definitions for the fractal_iter escape-time engine.
//   fractal_state_t    : engine state (IDLE, MUL, UPD, OUT)
//   escape_full_scale  : integer escape threshold on |z|^2, aligned to the
//                        fraction of a full-width (2*FP_WIDTH) product
// -----------------------------------------------------------------------------
package fractal_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_UPD  = 2'd2,
      ST_OUT  = 2'd3
   } fractal_state_t;

   // A full product of two values with frac_bits fraction bits carries
   // 2*frac_bits fraction bits, so the integer threshold moves up by that much.
   function automatic longint unsigned escape_full_scale(input int r2, input int frac_bits);
      longint unsigned r2_l;
      r2_l = longint'(r2);
      return r2_l << (2 * frac_bits);
   endfunction

endpackage

// File: rtl/fractal_iter_if.sv
// -----------------------------------------------------------------------------
// fractal_iter_if
// Coordinate-in / result-out handshake bundle for fractal_iter.
//   in_valid, in_ready, re, im     : coordinate offer (producer -> engine)
//   out_valid, out_ready, iter,
//   escaped                         : result (engine -> consumer)
// Modports:
//   master : the side offering coordinates and consuming results
//   slave  : the engine
// -----------------------------------------------------------------------------
interface fractal_iter_if #(
   parameter int FP_WIDTH = 25,
   parameter int ITERW    = 8
);
   logic                       in_valid;
   logic                       in_ready;
   logic signed [FP_WIDTH-1:0] re;
   logic signed [FP_WIDTH-1:0] im;
   logic                       out_valid;
   logic                       out_ready;
   logic [ITERW-1:0]           iter;
   logic                       escaped;

   modport master (
      output in_valid, re, im, out_ready,
      input  in_ready, out_valid, iter, escaped
   );

   modport slave (
      input  in_valid, re, im, out_ready,
      output in_ready, out_valid, iter, escaped
   );
endinterface

// File: rtl/fractal_iter_fp_mul_full.sv
// -----------------------------------------------------------------------------
// fp_mul_full
// Combinational signed FP_WIDTH x FP_WIDTH multiply returning the full
// 2*FP_WIDTH-bit product. No rounding or truncation is applied here.
//   a, b : signed operands
//   p    : signed full-width product
// -----------------------------------------------------------------------------
module fp_mul_full #(
   parameter int FP_WIDTH = 25
) (
   input  logic signed [FP_WIDTH-1:0]   a,
   input  logic signed [FP_WIDTH-1:0]   b,
   output logic signed [2*FP_WIDTH-1:0] p
);
   localparam int PW = 2 * FP_WIDTH;

   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] b_ext;

   // Sign-extend explicitly so the multiply is evaluated at full width.
   assign a_ext = {{FP_WIDTH{a[FP_WIDTH-1]}}, a};
   assign b_ext = {{FP_WIDTH{b[FP_WIDTH-1]}}, b};
   assign p     = a_ext * b_ext;
endmodule

// File: rtl/fractal_iter.sv
// -----------------------------------------------------------------------------
// fractal_iter
// Fixed-point escape-time engine: accepts one complex coordinate, iterates
// z <- z^2 + c (two cycles per iteration) and returns the iteration count
// plus an escape flag.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : fractal_iter_if.slave (coordinate in, result out)
//   abort      : drop the calculation in progress (MUL/UPD only)
//   busy       : high while iterating (MUL or UPD)
//   julia, jre, jim : Julia-mode select and constant, present only when the
//                     FRACTAL_JULIA_EN macro is defined
//
// Build option:
//   FRACTAL_JULIA_EN : adds Julia mode (z0 = coordinate, c = (jre, jim)).
//                      Undefined builds are Mandelbrot only.
// -----------------------------------------------------------------------------
module fractal_iter
   import fractal_pkg::*;
#(
   parameter int FP_WIDTH  = 25,
   parameter int FP_INT    = 4,
   parameter int ITER_MAX  = 255,
   parameter int ITERW     = $clog2(ITER_MAX + 1),
   parameter int ESCAPE_R2 = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   fractal_iter_if.slave              bus,
   input  logic                       abort,
   output logic                       busy
`ifdef FRACTAL_JULIA_EN
   ,
   input  logic                       julia,
   input  logic signed [FP_WIDTH-1:0] jre,
   input  logic signed [FP_WIDTH-1:0] jim
`endif
);
   localparam int FRAC = FP_WIDTH - FP_INT;
   localparam int PW   = 2 * FP_WIDTH;
   localparam int SW   = PW + 1;

   localparam logic signed [SW-1:0]    ESC_FULL   = SW'(escape_full_scale(ESCAPE_R2, FRAC));
   localparam logic        [ITERW-1:0] ITER_LIMIT = ITERW'(ITER_MAX);

   fractal_state_t state;

   logic             out_valid_q;
   logic [ITERW-1:0] iter_q;
   logic             escaped_q;
   logic             accept;

   logic signed [FP_WIDTH-1:0] x_p0;
   logic signed [FP_WIDTH-1:0] y_p0;
   logic signed [FP_WIDTH-1:0] c_re;
   logic signed [FP_WIDTH-1:0] c_im;

   logic signed [PW-1:0] xx_c;
   logic signed [PW-1:0] yy_c;
   logic signed [PW-1:0] xy_c;
   logic signed [PW-1:0] xx_p1;
   logic signed [PW-1:0] yy_p1;
   logic signed [PW-1:0] xy_p1;

   logic signed [SW-1:0]       mag_p2;
   logic                       esc_p2;
   logic signed [FP_WIDTH-1:0] x_next;
   logic signed [FP_WIDTH-1:0] y_next;

   // Drop the extra fraction bits of a full product and keep FP_WIDTH bits.
   function automatic logic signed [FP_WIDTH-1:0] fp_trunc(input logic signed [PW-1:0] p);
      return FP_WIDTH'(p >>> FRAC);
   endfunction

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.iter      = iter_q;
   assign bus.escaped   = escaped_q;
   assign accept        = bus.in_valid && (state == ST_IDLE);

   fp_mul_full #(.FP_WIDTH(FP_WIDTH)) u_mul_xx (.a(x_p0), .b(x_p0), .p(xx_c));
   fp_mul_full #(.FP_WIDTH(FP_WIDTH)) u_mul_yy (.a(y_p0), .b(y_p0), .p(yy_c));
   fp_mul_full #(.FP_WIDTH(FP_WIDTH)) u_mul_xy (.a(x_p0), .b(y_p0), .p(xy_c));

   // ---- p0 -> p1 : full products registered in MUL ----
   // ---- p1 -> p2 : magnitude test and next z, consumed in UPD ----
   // One extra bit keeps x^2 + y^2 exact; the strict compare makes |z|^2 == R2
   // a non-escape.
   assign mag_p2 = {xx_p1[PW-1], xx_p1} + {yy_p1[PW-1], yy_p1};
   assign esc_p2 = (mag_p2 > ESC_FULL);
   assign x_next = fp_trunc(xx_p1) - fp_trunc(yy_p1) + c_re;
   assign y_next = (fp_trunc(xy_p1) <<< 1) + c_im;

   // Datapath registers carry no reset; they are always loaded on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
`ifdef FRACTAL_JULIA_EN
         if (julia) begin
            x_p0 <= bus.re;
            y_p0 <= bus.im;
            c_re <= jre;
            c_im <= jim;
         end else begin
            x_p0 <= '0;
            y_p0 <= '0;
            c_re <= bus.re;
            c_im <= bus.im;
         end
`else
         x_p0 <= '0;
         y_p0 <= '0;
         c_re <= bus.re;
         c_im <= bus.im;
`endif
      end else if (state == ST_UPD) begin
         x_p0 <= x_next;
         y_p0 <= y_next;
      end
      if (state == ST_MUL) begin
         xx_p1 <= xx_c;
         yy_p1 <= yy_c;
         xy_p1 <= xy_c;
      end
   end

   // Control FSM: reset beats abort, abort beats the handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         out_valid_q <= 1'b0;
         iter_q      <= '0;
         escaped_q   <= 1'b0;
         busy        <= 1'b0;
      end else if (abort && (state == ST_MUL || state == ST_UPD)) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  state     <= ST_MUL;
                  busy      <= 1'b1;
                  iter_q    <= '0;
                  escaped_q <= 1'b0;
               end
            end
            ST_MUL: begin
               state <= ST_UPD;
            end
            ST_UPD: begin
               if (esc_p2) begin
                  state       <= ST_OUT;
                  busy        <= 1'b0;
                  out_valid_q <= 1'b1;
                  escaped_q   <= 1'b1;
               end else if (iter_q == ITER_LIMIT) begin
                  state       <= ST_OUT;
                  busy        <= 1'b0;
                  out_valid_q <= 1'b1;
                  escaped_q   <= 1'b0;
               end else begin
                  state  <= ST_MUL;
                  iter_q <= iter_q + 1'b1;
               end
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  state       <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fractal_iter.sv
// -----------------------------------------------------------------------------
// tb_fractal_iter
// Directed bench for fractal_iter with default parameters: a table of
// coordinates with hand-computed iteration counts, escape flags and result
// latencies, plus sequences for reset, backpressure, abort and reset-after-
// abort. Julia mode is exercised when FRACTAL_JULIA_EN is defined.
// -----------------------------------------------------------------------------
module tb_fractal_iter;
   localparam int FP_WIDTH = 25;
   localparam int FP_INT   = 4;
   localparam int FRAC     = FP_WIDTH - FP_INT;
   localparam int ITERW    = 8;
   localparam int LAT_CAP  = 2000;

   typedef logic signed [FP_WIDTH-1:0] fx_t;

   typedef struct {
      fx_t  re;
      fx_t  im;
      int   exp_iter;
      logic exp_esc;
      int   exp_lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic abort;
   logic busy;
`ifdef FRACTAL_JULIA_EN
   logic julia;
   fx_t  jre;
   fx_t  jim;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   fractal_iter_if #(.FP_WIDTH(FP_WIDTH), .ITERW(ITERW)) bus ();

   fractal_iter #(
      .FP_WIDTH (FP_WIDTH),
      .FP_INT   (FP_INT),
      .ITER_MAX (255),
      .ITERW    (ITERW),
      .ESCAPE_R2(4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .abort(abort),
      .busy (busy)
`ifdef FRACTAL_JULIA_EN
      ,
      .julia(julia),
      .jre  (jre),
      .jim  (jim)
`endif
   );

   always #5 clk = ~clk;

   // Value in 1/256 units -> fixed point.
   function automatic fx_t fx_q8(input int q8);
      return FP_WIDTH'(q8 <<< (FRAC - 8));
   endfunction

   function automatic vec_t mk(input int re_q8, input int im_q8, input int it,
                               input logic esc, input int lat);
      vec_t v;
      v.re       = fx_q8(re_q8);
      v.im       = fx_q8(im_q8);
      v.exp_iter = it;
      v.exp_esc  = esc;
      v.exp_lat  = lat;
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one coordinate, return cycles from the accept edge to out_valid.
   task automatic offer(input fx_t r, input fx_t i, output int lat);
      bus.re       = r;
      bus.im       = i;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < LAT_CAP) begin
         tick();
         lat++;
      end
   endtask

   vec_t vecs[$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int seen;

      rst           = 1'b1;
      abort         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.re        = '0;
      bus.im        = '0;
      bus.out_ready = 1'b1;
`ifdef FRACTAL_JULIA_EN
      julia = 1'b0;
      jre   = '0;
      jim   = '0;
`endif

      // Stimulus table: c in 1/256 units.
      vecs.push_back(mk(   0,    0, 255, 1'b0, 512));  // origin, never escapes
      vecs.push_back(mk( 512,    0,   2, 1'b1,   6));  // c = 2
      vecs.push_back(mk(-512,    0, 255, 1'b0, 512));  // c = -2, |z|^2 stays 4
      vecs.push_back(mk( 256,  256,   2, 1'b1,   6));  // c = 1+i
      vecs.push_back(mk( 128,    0,   5, 1'b1,  12));  // c = 0.5
      vecs.push_back(mk( 256,    0,   3, 1'b1,   8));  // c = 1
      vecs.push_back(mk(   0,  512,   2, 1'b1,   6));  // c = 2i
      vecs.push_back(mk(-512,  512,   1, 1'b1,   4));  // c = -2+2i
      vecs.push_back(mk(   0,  256, 255, 1'b0, 512));  // c = i, periodic orbit

      repeat (3) tick();
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset iter",      bus.iter,      0);
      chk("reset escaped",   bus.escaped,   0);
      chk("reset busy",      busy,          0);
      chk("reset in_ready",  bus.in_ready,  1);
      rst = 1'b0;
      tick();

      for (int k = 0; k < vecs.size(); k++) begin
         chk($sformatf("v%0d in_ready before", k), bus.in_ready, 1);
         offer(vecs[k].re, vecs[k].im, lat);
         chk($sformatf("v%0d latency", k), lat, vecs[k].exp_lat);
         chk($sformatf("v%0d iter", k), bus.iter, vecs[k].exp_iter);
         chk($sformatf("v%0d escaped", k), bus.escaped, vecs[k].exp_esc);
         tick();  // out_ready high: handshake on this edge
         chk($sformatf("v%0d out_valid drop", k), bus.out_valid, 0);
         chk($sformatf("v%0d in_ready after", k), bus.in_ready, 1);
      end

      // Backpressure: result held for 10 cycles, abort ignored in OUT.
      bus.out_ready = 1'b0;
      bus.re        = fx_q8(256);
      bus.im        = fx_q8(256);
      bus.in_valid  = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("bp busy after accept", busy, 1);
      chk("bp in_ready after accept", bus.in_ready, 0);
      lat = 0;
      while (!bus.out_valid && lat < LAT_CAP) begin
         tick();
         lat++;
      end
      chk("bp latency", lat, 6);
      for (int c = 0; c < 10; c++) begin
         abort = (c == 4);
         tick();
         chk($sformatf("bp hold%0d out_valid", c), bus.out_valid, 1);
         chk($sformatf("bp hold%0d iter", c), bus.iter, 2);
         chk($sformatf("bp hold%0d escaped", c), bus.escaped, 1);
         chk($sformatf("bp hold%0d in_ready", c), bus.in_ready, 0);
      end
      abort = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("bp out_valid after hs", bus.out_valid, 0);
      chk("bp in_ready after hs", bus.in_ready, 1);

      // Abort at cycle 20 after accept.
      bus.re       = '0;
      bus.im       = '0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (19) tick();
      chk("abort busy before", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort in_ready", bus.in_ready, 1);
      chk("abort busy", busy, 0);
      chk("abort out_valid", bus.out_valid, 0);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      chk("abort no result", seen, 0);

      // Abort then reset on the following cycle.
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (19) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      rst   = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort+rst out_valid", bus.out_valid, 0);
      chk("abort+rst iter",      bus.iter,      0);
      chk("abort+rst escaped",   bus.escaped,   0);
      chk("abort+rst busy",      busy,          0);
      chk("abort+rst in_ready",  bus.in_ready,  1);
      tick();

`ifdef FRACTAL_JULIA_EN
      // Julia: z0 = 2, c = 0 -> escapes after one iteration.
      julia = 1'b1;
      jre   = '0;
      jim   = '0;
      offer(fx_q8(512), fx_q8(0), lat);
      julia = 1'b0;
      chk("julia latency", lat, 4);
      chk("julia iter", bus.iter, 1);
      chk("julia escaped", bus.escaped, 1);
      tick();
      chk("julia in_ready after", bus.in_ready, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
